// File: rtl/sram_width_ctrl_if.sv
// sram_width_ctrl_if: request/response bus between a requester and sram_width_ctrl.
// Signals: cfg (width select), req_valid/req_ready/req_we/req_addr/req_wdata (request),
// rsp_valid/rsp_ready/rsp_rdata (read response). master = requester, slave = controller.
interface sram_width_ctrl_if #(parameter int ROW_BITS = 10);
  logic [2:0] cfg;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ROW_BITS+4:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  modport master (
    output cfg, req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input cfg, req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_width_ctrl.sv
// sram_width_ctrl: sequences single accesses to a 1k x 32 SRAM macro configured as x32..x1.
// Ports: clk, rst (async, active-high), bus (request/response, slave modport),
// sram_en/sram_we/sram_row/sram_bl_mask/sram_wdata to the macro, sram_rdata from it,
// cfg_err pulses when an illegal width select is accepted.
// Optional macro SRAM_RDATA_REG_EN: registers raw macro data and extracts in an extra state.
module sram_width_ctrl #(
  parameter int ROW_BITS = 10,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  sram_width_ctrl_if.slave bus,
  output logic sram_en,
  output logic sram_we,
  output logic [ROW_BITS-1:0] sram_row,
  output logic [31:0] sram_bl_mask,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic cfg_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EXTRACT, RESP, ERR} state_t;
  state_t state, next;
  logic legal;
  logic [5:0] w;
  logic [4:0] slot, off, off_q;
  logic [31:0] lane, lane_q, mask, mask_q, rdata_q, ext, src;
  logic [31:0] r [6];
  logic [ROW_BITS-1:0] row;
  logic [1:0] cnt;
  logic we_q;
`ifdef SRAM_RDATA_REG_EN
  logic [31:0] raw_q;
  assign src = raw_q;
`else
  assign src = sram_rdata;
`endif
  // Slot offset is slot*W, done as a shift since W is a power of two.
  always_comb begin
    legal = bus.cfg <= 3'd5;
    w = 6'd32 >> bus.cfg;
    lane = 32'hFFFF_FFFF >> (6'd32 - w);
    slot = bus.req_addr[4:0] & ~(5'h1F << bus.cfg);
    off = slot << (3'd5 - bus.cfg);
    row = ROW_BITS'(bus.req_addr >> bus.cfg);
    mask = lane << off;
    r[0] = bus.req_wdata & lane;
    for (int i = 1; i < 6; i++) r[i] = bus.cfg >= 3'(i) ? r[i-1] | (r[i-1] << (32 >> i)) : r[i-1];
    ext = (src >> off_q) & lane_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (bus.req_valid) next = legal ? ISSUE : ERR;
      ISSUE: next = we_q ? IDLE : WAIT;
`ifdef SRAM_RDATA_REG_EN
      WAIT: if (cnt == 2'd0) next = EXTRACT;
      EXTRACT: next = RESP;
`else
      WAIT: if (cnt == 2'd0) next = RESP;
`endif
      RESP: if (bus.rsp_ready) next = IDLE;
      ERR: next = we_q ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q <= 1'b0;
      off_q <= '0;
      lane_q <= '0;
      mask_q <= '0;
      sram_row <= '0;
      sram_wdata <= '0;
      cnt <= '0;
      rdata_q <= '0;
`ifdef SRAM_RDATA_REG_EN
      raw_q <= '0;
`endif
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q <= bus.req_we;
        if (legal) begin
          off_q <= off;
          lane_q <= lane;
          mask_q <= mask;
          sram_row <= row;
          sram_wdata <= r[5];
        end
      end
      if (state == ISSUE) cnt <= 2'(RD_LAT - 1);
      if (state == WAIT) cnt <= cnt - 2'd1;
`ifdef SRAM_RDATA_REG_EN
      if (state == WAIT && cnt == 2'd0) raw_q <= sram_rdata;
      if (state == EXTRACT) rdata_q <= ext;
`else
      if (state == WAIT && cnt == 2'd0) rdata_q <= ext;
`endif
      if (state == ERR) rdata_q <= '0;
    end
  // req_ready is gated by rst so every output reads 0 while reset is held.
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign sram_en = state == ISSUE;
  assign sram_we = sram_en && we_q;
  assign sram_bl_mask = sram_en ? mask_q : '0;
  assign cfg_err = state == ERR;
endmodule

// File: tb/tb_sram_width_ctrl.sv
// tb_sram_width_ctrl: vector table plus corner-case sequences with a response scoreboard.
module tb_sram_width_ctrl;
  localparam int ROW_BITS = 10;
  localparam int RD_LAT = 1;
`ifdef SRAM_RDATA_REG_EN
  localparam int EXP_LAT = RD_LAT + 2;
`else
  localparam int EXP_LAT = RD_LAT + 1;
`endif
  typedef struct {
    logic [2:0] cfg;
    logic we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [9:0] row;
    logic [31:0] mask;
    logic [31:0] swd;
    logic [31:0] rsp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sram_en, sram_we, cfg_err;
  logic [ROW_BITS-1:0] sram_row;
  logic [31:0] sram_bl_mask, sram_wdata, sram_rdata;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  vec_t vecs[11];
  vec_t s;
  sram_width_ctrl_if #(.ROW_BITS(ROW_BITS)) bus();
  sram_width_ctrl #(.ROW_BITS(ROW_BITS), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_row(sram_row),
    .sram_bl_mask(sram_bl_mask),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic logic any_out();
    return bus.req_ready | bus.rsp_valid | (|bus.rsp_rdata) | sram_en | sram_we | (|sram_row) |
           (|sram_bl_mask) | (|sram_wdata) | cfg_err;
  endfunction
  always @(negedge clk) begin
    #2;
    if (bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("rsp_rdata", bus.rsp_rdata, sb.pop_front());
    end
  end
  task automatic send(input vec_t v);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(n < 50), 32'd1);
    bus.cfg = v.cfg;
    bus.req_we = v.we;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    sram_rdata = v.rd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input string name, input int exp_lat);
    int lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_ready_low"}, 32'(bus.req_ready), 32'd0);
  endtask
  task automatic run(input vec_t v, input int idx);
    string n;
    n = $sformatf("v%0d", idx);
    send(v);
    check({n, "_en"}, 32'(sram_en), 32'd1);
    check({n, "_we"}, 32'(sram_we), 32'(v.we));
    check({n, "_row"}, 32'(sram_row), 32'(v.row));
    check({n, "_mask"}, sram_bl_mask, v.mask);
    if (v.we) begin
      check({n, "_wdata"}, sram_wdata, v.swd);
      @(negedge clk);
      check({n, "_ready_t2"}, 32'(bus.req_ready), 32'd1);
      check({n, "_en_off"}, 32'(sram_en), 32'd0);
      check({n, "_mask_off"}, sram_bl_mask, 32'd0);
      check({n, "_row_hold"}, 32'(sram_row), 32'(v.row));
    end else begin
      sb.push_back(v.rsp);
      wait_rsp(n, EXP_LAT);
      @(negedge clk);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cfg = 3'd0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    sram_rdata = '0;
    vecs[0]  = '{3'd0, 1'b1, 15'h0005, 32'hDEADBEEF, 32'h0, 10'h005, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{3'd0, 1'b0, 15'h0005, 32'h0, 32'hDEADBEEF, 10'h005, 32'hFFFFFFFF, 32'h0, 32'hDEADBEEF};
    vecs[2]  = '{3'd2, 1'b1, 15'h0017, 32'h000000A5, 32'h0, 10'h005, 32'hFF000000, 32'hA5A5A5A5, 32'h0};
    vecs[3]  = '{3'd2, 1'b0, 15'h0017, 32'h0, 32'hA5123456, 10'h005, 32'hFF000000, 32'h0, 32'h000000A5};
    vecs[4]  = '{3'd5, 1'b1, 15'h7FFF, 32'h1, 32'h0, 10'h3FF, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[5]  = '{3'd5, 1'b0, 15'h7FE0, 32'h0, 32'h00000001, 10'h3FF, 32'h00000001, 32'h0, 32'h1};
    vecs[6]  = '{3'd1, 1'b1, 15'h0003, 32'h1234ABCD, 32'h0, 10'h001, 32'hFFFF0000, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{3'd3, 1'b0, 15'h0026, 32'h0, 32'h3B000000, 10'h004, 32'h0F000000, 32'h0, 32'h0000000B};
    vecs[8]  = '{3'd4, 1'b1, 15'h000D, 32'hFFFFFFFE, 32'h0, 10'h000, 32'h0C000000, 32'hAAAAAAAA, 32'h0};
    vecs[9]  = '{3'd4, 1'b0, 15'h4035, 32'h0, 32'h00000C00, 10'h003, 32'h00000C00, 32'h0, 32'h3};
    vecs[10] = '{3'd0, 1'b0, 15'h4C05, 32'h0, 32'h12345678, 10'h005, 32'hFFFFFFFF, 32'h0, 32'h12345678};
    @(negedge clk);
    check("reset_outputs", 32'(any_out()), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) run(vecs[i], i);
    s = '{3'd6, 1'b0, 15'h0003, 32'h0, 32'hFFFFFFFF, 10'h0, 32'h0, 32'h0, 32'h0};
    send(s);
    check("err_rd_pulse", 32'(cfg_err), 32'd1);
    check("err_rd_no_en", 32'(sram_en), 32'd0);
    sb.push_back(32'h0);
    @(negedge clk);
    check("err_rd_pulse_end", 32'(cfg_err), 32'd0);
    check("err_rd_no_en2", 32'(sram_en), 32'd0);
    check("err_rd_rsp", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    check("err_rd_done", 32'(bus.rsp_valid), 32'd0);
    s = '{3'd7, 1'b1, 15'h0009, 32'h5, 32'h0, 10'h0, 32'h0, 32'h0, 32'h0};
    send(s);
    check("err_wr_pulse", 32'(cfg_err), 32'd1);
    check("err_wr_no_en", 32'(sram_en), 32'd0);
    @(negedge clk);
    check("err_wr_idle", 32'(bus.req_ready), 32'd1);
    check("err_wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
    s = '{3'd1, 1'b0, 15'h0001, 32'h0, 32'hBEEF1234, 10'h000, 32'hFFFF0000, 32'h0, 32'h0000BEEF};
    send(s);
    check("stall_mask", sram_bl_mask, 32'hFFFF0000);
    sb.push_back(s.rsp);
    wait_rsp("stall", EXP_LAT);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 15'h0009;
    bus.req_wdata = 32'h11;
    for (int i = 0; i < 5; i++) begin
      bus.cfg = 3'(i + 1);
      sram_rdata = $urandom;
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("stall%0d_rdata", i), bus.rsp_rdata, 32'h0000BEEF);
      check($sformatf("stall%0d_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.cfg = 3'd0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("handoff_idle_ready", 32'(bus.req_ready), 32'd1);
    check("handoff_idle_en", 32'(sram_en), 32'd0);
    check("handoff_rsp_done", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("handoff_en", 32'(sram_en), 32'd1);
    check("handoff_row", 32'(sram_row), 32'h009);
    check("handoff_wdata", sram_wdata, 32'h11);
    @(negedge clk);
    s = '{3'd0, 1'b0, 15'h0123, 32'h0, 32'h77777777, 10'h123, 32'hFFFFFFFF, 32'h0, 32'h0};
    send(s);
    check("rst_issue_row", 32'(sram_row), 32'h123);
    @(negedge clk);
    check("rst_in_wait", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_outputs", 32'(any_out()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.req_ready), 32'd1);
    run(vecs[2], 20);
    repeat (4) @(negedge clk);
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_width_ctrl.md
Name: sram_width_ctrl

Overview:
- Sequences single accesses to the 1k x 32 SRAM macro when configured as 1k x 32 down to 32k x 1.
- Accepts logical-address read/write requests over a valid/ready handshake and splits each logical address into a row and a slot.
- Drives the macro's enable, row, bit-line write mask and lane-replicated write data.
- On reads, extracts and zero-extends the addressed slot from the 32-bit row.

Parameters:
- ROW_BITS, 10, macro row address width (1k rows).
- RD_LAT, 1, macro read latency in cycles, counted from the cycle sram_en is high to the cycle sram_rdata is valid; legal range 1..4.

Ports:
- clk  input  1  sole clock.
- rst  input  1  reset, asynchronous, active-high.
- cfg  input  3  width select, sampled at accept: 000 = x32, 001 = x16, 010 = x8, 011 = x4, 100 = x2, 101 = x1; 110/111 illegal.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ROW_BITS+5  logical word address.
- req_wdata  input  32  write data; only the low W bits are used.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer takes read data.
- rsp_rdata  output  32  read data, zero-extended from W bits.
- sram_en  output  1  macro access strobe.
- sram_we  output  1  macro write enable.
- sram_row  output  ROW_BITS  macro row.
- sram_bl_mask  output  32  per-bit write enable; bit i enables column i.
- sram_wdata  output  32  macro write data.
- sram_rdata  input  32  macro read data.
- cfg_err  output  1  one-cycle pulse when an illegal cfg is accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset mid-operation drops the in-flight request and any pending response.
- Width decode: W = 32 >> cfg, S = cfg (slot bits).
  - slot = req_addr[S-1:0]; 0 when S = 0.
  - row = req_addr[S+ROW_BITS-1:S].
  - Address bits above S+ROW_BITS are ignored.
- Mask: sram_bl_mask bits [slot*W +: W] = 1, all other bits 0. For x32 the mask is all ones.
- Write data: sram_wdata = low W bits of req_wdata replicated 32/W times.
- Read extract: rsp_rdata = (sram_rdata >> slot*W) & (2^W - 1).
- Request fields (cfg, addr, we, wdata) are registered at accept. Later changes on cfg do not affect the in-flight access.
- FSM states:
  - IDLE: req_ready = 1. On req_valid: legal cfg -> ISSUE; illegal cfg -> ERR.
  - ISSUE (1 cycle): sram_en = 1, sram_we = we, sram_row and mask driven. Write -> IDLE. Read -> WAIT.
  - WAIT: a down-counter starts at RD_LAT-1. When it reaches 0, capture the extracted sram_rdata and go to RESP.
  - RESP: rsp_valid = 1 and held, with rsp_rdata stable, until rsp_ready. Then go to IDLE.
  - ERR (1 cycle): cfg_err = 1 and no macro access. Read -> RESP with rsp_rdata = 0. Write -> IDLE.
- Outside ISSUE: sram_en, sram_we and sram_bl_mask are 0; sram_row and sram_wdata hold their last values.
- Latency and throughput:
  - Write: accept at edge t, ISSUE in cycle t+1, req_ready high again at t+2.
  - Read: rsp_valid first high RD_LAT+1 cycles after ISSUE.
  - One outstanding request. Writes generate no response.
- Simultaneous events: rsp_ready is asserted with rsp_valid in RESP while a new req_valid is waiting. The next request is accepted one cycle later, because req_ready is low in RESP.

Optional Feature:
- SRAM_RDATA_REG_EN defined:
  - sram_rdata is registered raw at the end of WAIT.
  - Extraction happens from that register in an added EXTRACT state (1 cycle) before RESP.
  - Read latency grows by 1 cycle.
- SRAM_RDATA_REG_EN undefined: extraction is combinational in WAIT, as described above.

Test Plan:
- cfg = 000, write addr 0x005, wdata 0xDEADBEEF, then read addr 0x005 -> ISSUE shows row 5, mask 0xFFFFFFFF; rsp_rdata 0xDEADBEEF, with rsp_valid 2 cycles after ISSUE when RD_LAT = 1.
- cfg = 010 (x8), write addr 0x0017, wdata 0xA5 -> row 5, sram_bl_mask 0xFF000000, sram_wdata 0xA5A5A5A5. Then with sram_rdata = 0xA5123456, read addr 0x0017 -> rsp_rdata 0x000000A5.
- cfg = 101 (x1), write addr 0x7FFF, wdata 1 -> row 0x3FF, mask 0x80000000. Then read addr 0x7FE0 with sram_rdata = 0x00000001 -> rsp_rdata 1.
- cfg = 110, read request -> cfg_err pulses once, sram_en never asserted, rsp_rdata 0.
- Read in x16 with rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready low, and cfg changes during the stall are ignored.
- Assert rst during WAIT -> all outputs 0 immediately, no rsp_valid after release, and a fresh request is accepted the first cycle after rst falls.
